// File: rtl/dac_feeder_pkg.sv
// Shared types and constants for the DAC sample feeder.
package dac_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_e;

    localparam int unsigned PRIME_LEVEL = 2;

    function automatic logic [31:0] midscale(input int unsigned bitdepth);
        return 32'd1 << (bitdepth - 1);
    endfunction

endpackage

// File: rtl/dac_fifo.sv
// Synchronous FIFO with occupancy output and single-cycle flush.
module dac_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; a write during flush lands in a slot that is discarded.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/dac_feeder.sv
// Paced PCM feeder: FIFO-buffered samples released to a DAC on a divided strobe.
// Optional underrun event counter enabled by defining DAC_FEEDER_UNDERRUN_CNT_EN.
module dac_feeder
    import dac_feeder_pkg::*;
#(
    parameter int unsigned BITDEPTH = 12,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DIV_W-1:0]    divider,
    input  logic                wr_valid,
    input  logic [BITDEPTH-1:0] wr_data,
    output logic                wr_ready,
    output logic [FIFO_AW:0]    level,
    output logic                low_water,
    output logic                sample_strobe,
    output logic [BITDEPTH-1:0] pcm,
    output logic                underrun,
    input  logic                underrun_clr,
    output logic [7:0]          underrun_cnt
);

    localparam logic [BITDEPTH-1:0] MID       = BITDEPTH'(midscale(BITDEPTH));
    localparam logic [FIFO_AW:0]    PRIME_LVL = (FIFO_AW+1)'(PRIME_LEVEL);
    localparam logic [FIFO_AW:0]    HALF_LVL  = (FIFO_AW+1)'(1 << (FIFO_AW - 1));

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                strobe_q, strobe_d;
    logic [BITDEPTH-1:0] pcm_q, pcm_d;
    logic                underrun_q, underrun_d;

    logic                tc, ur_set;
    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [BITDEPTH-1:0] fifo_head;
    logic [FIFO_AW:0]    fifo_level;

    assign wr_ready  = rst && !fifo_full;
    assign fifo_push = wr_valid && wr_ready;
    assign level     = fifo_level;
    assign low_water = (fifo_level < HALF_LVL);

    dac_fifo #(
        .WIDTH (BITDEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .push_i    (fifo_push),
        .pop_i     (fifo_pop),
        .flush_i   (fifo_flush),
        .wr_data_i (wr_data),
        .rd_data_o (fifo_head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign tc = (state_q != ST_IDLE) && (cnt_q == divider);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        strobe_d   = 1'b0;
        pcm_d      = pcm_q;
        ur_set     = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        if (!enable) begin
            // Flush only on leaving playback so samples can be preloaded while idle.
            state_d    = ST_IDLE;
            cnt_d      = '0;
            pcm_d      = MID;
            fifo_flush = (state_q != ST_IDLE);
        end else if (state_q == ST_IDLE) begin
            state_d = ST_PRIME;
        end else begin
            cnt_d    = tc ? '0 : cnt_q + DIV_W'(1);
            strobe_d = tc;
            case (state_q)
                ST_PRIME: begin
                    if (fifo_level >= PRIME_LVL) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tc) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            pcm_d    = fifo_head;
                        end else begin
                            state_d = ST_UNDERRUN;
                            pcm_d   = MID;
                            ur_set  = 1'b1;
                        end
                    end
                end
                ST_UNDERRUN: begin
                    if (fifo_level >= PRIME_LVL) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        if (ur_set)            underrun_d = 1'b1;
        else if (underrun_clr) underrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            pcm_q      <= MID;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            strobe_q   <= strobe_d;
            pcm_q      <= pcm_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign pcm           = pcm_q;
    assign underrun      = underrun_q;

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (ur_set) begin
            if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
        end else if (underrun_clr) begin
            ucnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) ucnt_q <= '0;
        else      ucnt_q <= ucnt_d;
    end

    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_feeder.sv
// Scoreboard bench for dac_feeder: queue-based playback model predicts strobes and status.
module tb_dac_feeder;

    localparam int BD  = 12;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int MID = 2048;
    localparam int CAP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] divider = '0;
    logic          wr_valid = 1'b0;
    logic [BD-1:0] wr_data = '0;
    logic          underrun_clr = 1'b0;
    logic          wr_ready;
    logic [AW:0]   level;
    logic          low_water;
    logic          sample_strobe;
    logic [BD-1:0] pcm;
    logic          underrun;
    logic [7:0]    underrun_cnt;

    always #5 clk = ~clk;

    dac_feeder #(
        .BITDEPTH (BD),
        .DIV_W    (DW),
        .FIFO_AW  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .divider       (divider),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .level         (level),
        .low_water     (low_water),
        .sample_strobe (sample_strobe),
        .pcm           (pcm),
        .underrun      (underrun),
        .underrun_clr  (underrun_clr),
        .underrun_cnt  (underrun_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Playback model: a sample queue, a phase within the sample period, and a playback mode.
    typedef enum {M_OFF, M_WAIT, M_PLAY, M_STARVED} mode_t;
    typedef struct {
        int cyc;
        int pcm;
    } ev_t;

    mode_t mode   = M_OFF;
    int    fm[$];
    int    since  = 0;
    int    m_pcm  = MID;
    bit    m_ur   = 1'b0;
    int    m_cnt  = 0;
    ev_t   exp_q[$];
    bit    m_push, m_set, m_tc;
    int    m_n;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            fm.delete();
            mode  = M_OFF;
            since = 0;
            m_pcm = MID;
            m_ur  = 1'b0;
            m_cnt = 0;
        end else begin
            m_set  = 1'b0;
            m_n    = fm.size();
            m_push = wr_valid && (m_n < CAP);
            if (!enable) begin
                if (mode != M_OFF) begin
                    fm.delete();
                    m_push = 1'b0;
                end
                mode  = M_OFF;
                since = 0;
                m_pcm = MID;
            end else if (mode == M_OFF) begin
                mode = M_WAIT;
            end else begin
                m_tc  = (since == int'(divider));
                since = m_tc ? 0 : (since + 1) % 65536;
                if (m_tc) begin
                    if (mode == M_PLAY) begin
                        if (m_n > 0) begin
                            m_pcm = fm.pop_front();
                        end else begin
                            mode  = M_STARVED;
                            m_pcm = MID;
                            m_set = 1'b1;
                        end
                    end
                    exp_q.push_back('{cyc, m_pcm});
                end
                if ((mode == M_WAIT || mode == M_STARVED) && m_n >= 2 && !m_set)
                    mode = M_PLAY;
            end
            if (m_push) fm.push_back(int'(wr_data));
            if (m_set) begin
                m_ur = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else if (underrun_clr) begin
                m_ur  = 1'b0;
                m_cnt = 0;
            end
        end
    end

    ev_t ev;
    int  exp_cnt;

    always @(negedge clk) begin
        if (sample_strobe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                ev = exp_q.pop_front();
                chk("strobe_cycle", cyc, ev.cyc);
                chk("strobe_pcm", int'(pcm), ev.pcm);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("missing_strobe_at", exp_q[0].cyc, -1);
            void'(exp_q.pop_front());
        end
`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("level", int'(level), fm.size());
        chk("wr_ready", int'(wr_ready), int'(rst && fm.size() < CAP));
        chk("low_water", int'(low_water), int'(fm.size() < CAP / 2));
        chk("pcm", int'(pcm), m_pcm);
        chk("underrun", int'(underrun), int'(m_ur));
        chk("underrun_cnt", int'(underrun_cnt), exp_cnt);
    end

    task automatic drive(input bit r, input bit en, input bit wv, input int wd,
                         input bit clr, input int dv);
        @(negedge clk);
        #1;
        rst          = r;
        enable       = en;
        wr_valid     = wv;
        wr_data      = BD'(wd);
        underrun_clr = clr;
        divider      = DW'(dv);
    endtask

    bit en_r;

    initial begin
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 3);
        drive(1, 0, 0, 0, 0, 3);
        chk("rst_pcm", int'(pcm), 'h800);
        chk("rst_strobe", int'(sample_strobe), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);

        // Preloaded three samples, divider 3: four strobes then underrun.
        drive(1, 0, 1, 'h100, 0, 3);
        drive(1, 0, 1, 'h200, 0, 3);
        drive(1, 0, 1, 'h300, 0, 3);
        repeat (20) drive(1, 1, 0, 0, 0, 3);
        chk("req25_underrun", int'(underrun), 1);

        // Refill while starved: playback resumes, flag stays sticky.
        drive(1, 1, 1, 'h0AA, 0, 3);
        drive(1, 1, 1, 'h0BB, 0, 3);
        repeat (10) drive(1, 1, 0, 0, 0, 3);
        chk("req27_sticky", int'(underrun), 1);
        drive(1, 0, 0, 0, 1, 3);
        drive(1, 0, 0, 0, 0, 3);
        chk("req27_cleared", int'(underrun), 0);

        // Fill to capacity while idle; extra push is dropped.
        for (int i = 0; i < 17; i++) drive(1, 0, 1, 16 + i, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        chk("full_level", int'(level), 16);
        chk("full_wr_ready", int'(wr_ready), 0);
        for (int i = 0; i < 40; i++) drive(1, 1, 1, $urandom_range(0, 4095), 0, 1);

        // Disable mid-playback with five samples buffered.
        drive(1, 0, 0, 0, 0, 20);
        for (int i = 0; i < 6; i++) drive(1, 0, 1, 'h400 + i, 0, 20);
        repeat (28) drive(1, 1, 0, 0, 0, 20);
        chk("req28_level5", int'(level), 5);
        drive(1, 0, 0, 0, 0, 20);
        drive(1, 0, 0, 0, 0, 20);
        chk("req28_flush_level", int'(level), 0);
        chk("req28_flush_pcm", int'(pcm), 'h800);
        chk("req28_flush_strobe", int'(sample_strobe), 0);

        // Reset in the middle of playback.
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 'h123 + i, 0, 2);
        repeat (12) drive(1, 1, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 2);
        drive(1, 0, 0, 0, 0, 2);
        chk("midrst_pcm", int'(pcm), 'h800);
        chk("midrst_level", int'(level), 0);
        chk("midrst_strobe", int'(sample_strobe), 0);
        chk("midrst_underrun", int'(underrun), 0);

        // Randomised traffic; divider only changes while disabled.
        en_r = 1'b1;
        for (int i = 0, dv = 2; i < 2500; i++) begin
            if ($urandom_range(0, 119) == 0) en_r = !en_r;
            if (!en_r && $urandom_range(0, 9) == 0) dv = $urandom_range(0, 6);
            drive($urandom_range(0, 399) != 0, en_r, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4095), $urandom_range(0, 39) == 0, dv);
        end

        repeat (3) drive(1, 0, 0, 0, 0, 0);
        chk("strobes_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
